// File: rtl/riscv_defines.sv
// rtl/riscv_defines.sv - shared privilege-level and interrupt arbiter FSM types
package riscv_defines;

   typedef enum logic [1:0] {
      PRIV_LVL_U = 2'b00,
      PRIV_LVL_S = 2'b01,
      PRIV_LVL_H = 2'b10,
      PRIV_LVL_M = 2'b11
   } PrivLvl_t;

   typedef enum logic [1:0] {
      IRQ_IDLE    = 2'b00,
      IRQ_PENDING = 2'b01,
      IRQ_DONE    = 2'b10
   } irq_state_e;

endpackage

// File: rtl/riscv_irq_prio_enc.sv
// rtl/riscv_irq_prio_enc.sv - fixed-priority encoder, highest set index wins
module riscv_irq_prio_enc #(
   parameter int NUM_IRQ = 32,
   localparam int ID_W = $clog2(NUM_IRQ)
) (
   input  logic [NUM_IRQ-1:0] req_i,
   output logic               valid_o,
   output logic [ID_W-1:0]    id_o,
   output logic [NUM_IRQ-1:0] onehot_o
);

   always_comb begin
      valid_o  = 1'b0;
      id_o     = '0;
      onehot_o = '0;
      // Ascending scan: a later (higher) hit overrides earlier ones.
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (req_i[i]) begin
            valid_o     = 1'b1;
            id_o        = ID_W'(i);
            onehot_o    = '0;
            onehot_o[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/riscv_irq_arbiter.sv
// rtl/riscv_irq_arbiter.sv - interrupt capture/arbitration FSM; RISCV_IRQ_PREEMPT_EN enables re-arbitration while pending
module riscv_irq_arbiter
   import riscv_defines::*;
#(
   parameter int NUM_IRQ     = 32,
   parameter int PULP_SECURE = 0,
   localparam int ID_W = $clog2(NUM_IRQ)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [NUM_IRQ-1:0] irq_mask_i,
   input  logic [NUM_IRQ-1:0] irq_sec_i,
   input  logic               m_ie_i,
   input  logic               u_ie_i,
   input  PrivLvl_t           priv_lvl_i,
   input  logic               ctrl_ack_i,
   input  logic               ctrl_kill_i,
   output logic               irq_req_ctrl_o,
   output logic [ID_W-1:0]    irq_id_ctrl_o,
   output logic               irq_sec_ctrl_o,
   output logic [NUM_IRQ-1:0] irq_onehot_o
);

   localparam logic [NUM_IRQ-1:0] NMI_BIT = {1'b1, {(NUM_IRQ-1){1'b0}}};

   irq_state_e         state_q, state_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic               sec_q, sec_d;
   logic [NUM_IRQ-1:0] onehot_q, onehot_d;

   logic [NUM_IRQ-1:0] cand;
   logic               win_valid;
   logic [ID_W-1:0]    win_id;
   logic [NUM_IRQ-1:0] win_onehot;
   logic               win_sec;
   logic               glob_en;
   logic               cand_en;

   assign cand = irq_i & (irq_mask_i | NMI_BIT);

   riscv_irq_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
      .req_i    (cand),
      .valid_o  (win_valid),
      .id_o     (win_id),
      .onehot_o (win_onehot)
   );

   assign win_sec = |(win_onehot & irq_sec_i);

   always_comb begin
      glob_en = m_ie_i;
      if (PULP_SECURE != 0) begin
         glob_en = ((u_ie_i | win_sec) & (priv_lvl_i == PRIV_LVL_U)) |
                   (m_ie_i & (priv_lvl_i == PRIV_LVL_M));
      end
   end

   // The NMI is never gated by the global enables.
   assign cand_en = win_valid & (win_onehot[NUM_IRQ-1] | glob_en);

   always_comb begin
      state_d  = state_q;
      id_d     = id_q;
      sec_d    = sec_q;
      onehot_d = onehot_q;
      case (state_q)
         IRQ_IDLE: begin
            if (cand_en) begin
               state_d  = IRQ_PENDING;
               id_d     = win_id;
               sec_d    = win_sec;
               onehot_d = win_onehot;
            end
         end
         IRQ_PENDING: begin
            if (ctrl_ack_i) begin
               state_d  = IRQ_DONE;
               sec_d    = 1'b0;
               onehot_d = '0;
            end else if (ctrl_kill_i) begin
               state_d  = IRQ_IDLE;
               sec_d    = 1'b0;
               onehot_d = '0;
            end
`ifdef RISCV_IRQ_PREEMPT_EN
            else if (cand_en && (win_id > id_q)) begin
               id_d     = win_id;
               sec_d    = win_sec;
               onehot_d = win_onehot;
            end
`else
            else begin
               state_d = IRQ_PENDING;
            end
`endif
         end
         IRQ_DONE: begin
            state_d  = IRQ_IDLE;
            sec_d    = 1'b0;
            onehot_d = '0;
         end
         default: begin
            state_d  = IRQ_IDLE;
            sec_d    = 1'b0;
            onehot_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IRQ_IDLE;
         id_q     <= '0;
         sec_q    <= 1'b0;
         onehot_q <= '0;
      end else begin
         state_q  <= state_d;
         id_q     <= id_d;
         sec_q    <= sec_d;
         onehot_q <= onehot_d;
      end
   end

   assign irq_req_ctrl_o = (state_q == IRQ_PENDING);
   assign irq_id_ctrl_o  = id_q;
   assign irq_sec_ctrl_o = sec_q;
   assign irq_onehot_o   = onehot_q;

endmodule

// File: doc/riscv_irq_arbiter.md
RISCV_IRQ_ARBITER -- requirements
Module: riscv_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_IRQ, default 32, number of interrupt lines (legal 2..64); line NUM_IRQ-1 is the NMI.
REQ-002 SHALL have parameter PULP_SECURE, default 0, enables U-mode/secure enable qualification.
REQ-003 SHALL have localparam ID_W = $clog2(NUM_IRQ), the width of the interrupt ID.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 irq_i  input  NUM_IRQ  level-triggered interrupt lines.
REQ-007 irq_mask_i  input  NUM_IRQ  per-line enable (mie); bit NUM_IRQ-1 ignored.
REQ-008 irq_sec_i  input  NUM_IRQ  per-line secure attribute.
REQ-009 m_ie_i / u_ie_i  input  1 each  global M-mode / U-mode interrupt enable.
REQ-010 priv_lvl_i  input  PrivLvl_t  current privilege level.
REQ-011 ctrl_ack_i / ctrl_kill_i  input  1 each  controller accept / abandon.
REQ-012 irq_req_ctrl_o  output  1  request pending to controller.
REQ-013 irq_id_ctrl_o  output  ID_W  captured interrupt ID.
REQ-014 irq_sec_ctrl_o  output  1  captured secure bit.
REQ-015 irq_onehot_o  output  NUM_IRQ  one-hot of captured ID, zero when no request held.

Function
REQ-016 Candidates SHALL be irq_i & irq_mask_i, with bit NUM_IRQ-1 taken from irq_i unmasked.
REQ-017 Global enable SHALL be m_ie_i when PULP_SECURE=0; else ((u_ie_i | sec of winner) & priv==U) | (m_ie_i & priv==M); NMI bypasses global enable.
REQ-018 Arbitration SHALL be fixed priority, highest index wins.
REQ-019 FSM states SHALL be IDLE, PENDING, DONE.
REQ-020 IDLE: on any enabled candidate, capture winner ID, one-hot and secure bit, go PENDING; else hold.
REQ-021 Latency SHALL be one cycle: irq sampled at edge N gives irq_req_ctrl_o=1 after edge N.
REQ-022 irq_req_ctrl_o SHALL equal (state==PENDING), registered-state decode only.
REQ-023 PENDING: ctrl_ack_i -> DONE; else ctrl_kill_i -> IDLE with onehot and sec cleared; else hold.
REQ-024 Simultaneous ack and kill SHALL be treated as ack.
REQ-025 Captured request SHALL persist if irq_i deasserts while PENDING.
REQ-026 DONE: clear sec and onehot, keep ID, return to IDLE after exactly one cycle; no capture in DONE.
REQ-027 ack/kill in IDLE or DONE SHALL be ignored.

Reset
REQ-028 On rst_n low, state SHALL be IDLE and all outputs zero, immediately (asynchronous), including mid-PENDING.
REQ-029 First capture SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-030 Macro RISCV_IRQ_PREEMPT_EN SHALL control re-arbitration in PENDING.
REQ-031 With RISCV_IRQ_PREEMPT_EN: in PENDING without ack/kill, a higher-index enabled candidate SHALL replace ID, one-hot and sec next cycle, staying PENDING.
REQ-032 Without RISCV_IRQ_PREEMPT_EN: captured values SHALL be frozen until ack or kill.

Structure
REQ-033 PrivLvl_t and the FSM state enum SHALL live in riscv_defines.
REQ-034 Priority encoding SHALL be a sub-module riscv_irq_prio_enc (parameter NUM_IRQ; outputs valid, ID, one-hot).

Verification
REQ-035 NUM_IRQ=32, mask=all-ones, m_ie=1, irq_i=0x0000_0880 -> next cycle req=1, id=11, onehot=0x0000_0800.
REQ-036 m_ie=0, irq_i=0x8000_0000 -> req=1, id=31 (NMI); irq_i=0x0000_0008 with m_ie=0 -> req stays 0.
REQ-037 PENDING id=7, ack=kill=1 same cycle -> DONE then IDLE, sec=0, onehot=0 after two edges.
REQ-038 PENDING id=3, irq_i rises bit 20: with macro -> id=20 next cycle; without -> id stays 3.
REQ-039 rst_n low mid-PENDING -> req, onehot, sec, id =0 without clock edge; PULP_SECURE=1, priv=U, u_ie=0, irq_sec_i[5]=1, irq_i[5]=1 -> id=5 accepted.
